// File: rtl/pc_ctrl.sv
// pc_ctrl: control side of the fetch stage.
// Collects PC-redirect events and issues one registered command per clock
// on the pc_place / pc_select / index bus that fetch samples.
// It also runs the interrupt entry sequence: pend, drain, vector, acknowledge.
//
// Ports:
//   clk         rising-edge clock
//   rst_n       synchronous reset, active-low
//   stall       hazard stall, hold PC
//   inst_is_32  current fetched instruction occupies two words
//   exc_valid   hardware exception pulse; exc_code selects vector 0..3
//   int_req     external interrupt request; int_index is its IVT index
//   call_en     resolved call, redirect to the call target
//   ret_en      resolved return, redirect to the popped return address
//   pc_place    redirect code: 0 seq, 1..4 fixed vectors, 5 IVT, 6 ret,
//               7 call, 8 reset
//   pc_select   increment code when pc_place = 0: 0 hold, 1 +1, 2 +2
//   index       IVT offset, updated only when vectoring
//   flush       kill younger in-flight instructions
//   int_ack     one-cycle interrupt acknowledge
//   busy        a sequence is in progress (state is not RUN)
module pc_ctrl #(
  parameter int DRAIN_CYCLES = 3,
  parameter int CNT_W        = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       stall,
  input  logic       inst_is_32,
  input  logic       exc_valid,
  input  logic [1:0] exc_code,
  input  logic       int_req,
  input  logic [2:0] int_index,
  input  logic       call_en,
  input  logic       ret_en,
  output logic [3:0] pc_place,
  output logic [1:0] pc_select,
  output logic [2:0] index,
  output logic       flush,
  output logic       int_ack,
  output logic       busy
);

  typedef enum logic [1:0] {RST_VEC, RUN, DRAIN, VEC} state_t;

  state_t           state_reg, state_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic             pending_reg, pending_next;
  logic [2:0]       idx_reg, idx_next;
  logic [3:0]       place_reg, place_next;
  logic [1:0]       select_reg, select_next;
  logic [2:0]       index_reg, index_next;
  logic             flush_reg, flush_next;
  logic             ack_reg, ack_next;
  logic             busy_reg, busy_next;

  always_comb begin
    state_next   = state_reg;
    cnt_next     = cnt_reg;
    pending_next = pending_reg;
    idx_next     = idx_reg;
    place_next   = 4'd0;
    select_next  = 2'd0;
    index_next   = index_reg;
    flush_next   = 1'b0;
    ack_next     = 1'b0;

    // Any request not yet held is captured here, so a request that loses
    // to a redirect or a stall is not lost. The first index held wins
    // until the acknowledge clears pending.
    if (int_req && !pending_reg) begin
      pending_next = 1'b1;
      idx_next     = int_index;
    end

    case (state_reg)
      RST_VEC: begin
        place_next = 4'd8;
        flush_next = 1'b1;
        state_next = RUN;
      end
      RUN: begin
        if (exc_valid) begin
          place_next = 4'(exc_code) + 4'd1;
          flush_next = 1'b1;
        end else if (ret_en) begin
          place_next = 4'd6;
          flush_next = 1'b1;
        end else if (call_en) begin
          place_next = 4'd7;
          flush_next = 1'b1;
        end else if ((pending_reg || int_req) && !stall) begin
          flush_next = 1'b1;
          cnt_next   = CNT_W'(DRAIN_CYCLES - 1);
          state_next = DRAIN;
        end else if (!stall) begin
          select_next = inst_is_32 ? 2'd2 : 2'd1;
        end
      end
      DRAIN: begin
        flush_next = 1'b1;
        if (exc_valid) begin
          // Exception wins; pending stays set so entry is retried from RUN.
          place_next = 4'(exc_code) + 4'd1;
          state_next = RUN;
        end else if (cnt_reg == '0) begin
          state_next = VEC;
        end else begin
          cnt_next = cnt_reg - 1'b1;
        end
      end
      VEC: begin
        place_next   = 4'd5;
        index_next   = idx_reg;
        ack_next     = 1'b1;
        flush_next   = 1'b1;
        pending_next = 1'b0;
        state_next   = RUN;
      end
      default: state_next = RST_VEC;
    endcase

    busy_next = (state_next != RUN);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg   <= RST_VEC;
      cnt_reg     <= '0;
      pending_reg <= 1'b0;
      idx_reg     <= 3'd0;
      place_reg   <= 4'd0;
      select_reg  <= 2'd0;
      index_reg   <= 3'd0;
      flush_reg   <= 1'b0;
      ack_reg     <= 1'b0;
      busy_reg    <= 1'b1;
    end else begin
      state_reg   <= state_next;
      cnt_reg     <= cnt_next;
      pending_reg <= pending_next;
      idx_reg     <= idx_next;
      place_reg   <= place_next;
      select_reg  <= select_next;
      index_reg   <= index_next;
      flush_reg   <= flush_next;
      ack_reg     <= ack_next;
      busy_reg    <= busy_next;
    end
  end

  assign pc_place  = place_reg;
  assign pc_select = select_reg;
  assign index     = index_reg;
  assign flush     = flush_reg;
  assign int_ack   = ack_reg;
  assign busy      = busy_reg;

endmodule

// File: tb/tb_pc_ctrl.sv
// tb_pc_ctrl: directed scenarios with literal expectations, then a random
// phase. A cycle-level behavioural model tracks remaining drain cycles and
// a pending interrupt, and its expected outputs are compared on every
// falling edge.
module tb_pc_ctrl;
  localparam int DRAIN = 3;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       stall = 1'b0, inst_is_32 = 1'b0, exc_valid = 1'b0;
  logic [1:0] exc_code = 2'd0;
  logic       int_req = 1'b0;
  logic [2:0] int_index = 3'd0;
  logic       call_en = 1'b0, ret_en = 1'b0;
  logic [3:0] pc_place;
  logic [1:0] pc_select;
  logic [2:0] index;
  logic       flush, int_ack, busy;

  int checks = 0;
  int errors = 0;

  pc_ctrl #(.DRAIN_CYCLES(DRAIN), .CNT_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .stall(stall), .inst_is_32(inst_is_32),
    .exc_valid(exc_valid), .exc_code(exc_code), .int_req(int_req),
    .int_index(int_index), .call_en(call_en), .ret_en(ret_en),
    .pc_place(pc_place), .pc_select(pc_select), .index(index),
    .flush(flush), .int_ack(int_ack), .busy(busy)
  );

  always #5 clk = ~clk;

  // Behavioural model: booting, cycles of drain left, vector due next,
  // and a pending request with its index.
  bit         model_ok = 1'b0;
  bit         boot_m, vec_m, pend_m;
  int         drain_m;
  logic [2:0] pidx_m;
  logic [3:0] e_place;
  logic [1:0] e_sel;
  logic [2:0] e_index;
  logic       e_flush, e_ack, e_busy;

  always @(posedge clk) begin
    if (!rst_n) begin
      boot_m = 1; vec_m = 0; pend_m = 0; drain_m = 0; pidx_m = 0;
      e_place = 0; e_sel = 0; e_index = 0; e_flush = 0; e_ack = 0; e_busy = 1;
      model_ok = 1;
    end else if (model_ok) begin
      e_place = 0; e_sel = 0; e_flush = 0; e_ack = 0;
      if (int_req && !pend_m) begin
        pend_m = 1; pidx_m = int_index;
      end
      if (boot_m) begin
        e_place = 8; e_flush = 1; boot_m = 0;
      end else if (vec_m) begin
        e_place = 5; e_index = pidx_m; e_ack = 1; e_flush = 1;
        pend_m = 0; vec_m = 0;
      end else if (drain_m > 0) begin
        e_flush = 1;
        if (exc_valid) begin
          e_place = 4'(exc_code) + 4'd1; drain_m = 0;
        end else begin
          drain_m = drain_m - 1;
          if (drain_m == 0) vec_m = 1;
        end
      end else begin
        if (exc_valid) begin
          e_place = 4'(exc_code) + 4'd1; e_flush = 1;
        end else if (ret_en) begin
          e_place = 6; e_flush = 1;
        end else if (call_en) begin
          e_place = 7; e_flush = 1;
        end else if (pend_m && !stall) begin
          e_flush = 1; drain_m = DRAIN;
        end else if (!stall) begin
          e_sel = inst_is_32 ? 2'd2 : 2'd1;
        end
      end
      e_busy = boot_m || vec_m || (drain_m > 0);
    end
  end

  task automatic cmp(input string name, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d at %0t", name, got, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (model_ok) begin
      cmp("model_pc_place", 8'(pc_place), 8'(e_place));
      cmp("model_pc_select", 8'(pc_select), 8'(e_sel));
      cmp("model_index", 8'(index), 8'(e_index));
      cmp("model_flush", 8'(flush), 8'(e_flush));
      cmp("model_int_ack", 8'(int_ack), 8'(e_ack));
      cmp("model_busy", 8'(busy), 8'(e_busy));
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Reset release
    rst_n = 0; step(); step();
    cmp("rst_place", 8'(pc_place), 8'd0);
    cmp("rst_busy", 8'(busy), 8'd1);
    cmp("rst_flush", 8'(flush), 8'd0);
    rst_n = 1; step();
    cmp("boot_place", 8'(pc_place), 8'd8);
    cmp("boot_flush", 8'(flush), 8'd1);
    step();
    cmp("run_place", 8'(pc_place), 8'd0);
    cmp("run_select", 8'(pc_select), 8'd1);
    cmp("run_busy", 8'(busy), 8'd0);
    $display("scenario reset release done");

    // Length and stall
    inst_is_32 = 1; step();
    cmp("len32_select", 8'(pc_select), 8'd2);
    stall = 1; step();
    cmp("stall_select", 8'(pc_select), 8'd0);
    stall = 0; step();
    cmp("unstall_select", 8'(pc_select), 8'd2);
    inst_is_32 = 0;
    $display("scenario length and stall done");

    // Interrupt entry
    int_req = 1; int_index = 5; step();
    int_req = 0;
    cmp("entry_flush", 8'(flush), 8'd1);
    cmp("entry_busy", 8'(busy), 8'd1);
    for (int i = 0; i < DRAIN; i++) begin
      step();
      cmp("drain_flush", 8'(flush), 8'd1);
      cmp("drain_select", 8'(pc_select), 8'd0);
    end
    step();
    cmp("vec_place", 8'(pc_place), 8'd5);
    cmp("vec_index", 8'(index), 8'd5);
    cmp("vec_ack", 8'(int_ack), 8'd1);
    step();
    cmp("post_vec_ack", 8'(int_ack), 8'd0);
    cmp("post_vec_select", 8'(pc_select), 8'd1);
    $display("scenario interrupt entry done");

    // Priority
    exc_valid = 1; exc_code = 2; ret_en = 1; call_en = 1; step();
    cmp("prio_place", 8'(pc_place), 8'd3);
    exc_valid = 0; call_en = 0; step();
    cmp("ret_place", 8'(pc_place), 8'd6);
    ret_en = 0; step();
    $display("scenario priority done");

    // Pending interrupt: first index wins
    stall = 1; int_req = 1; int_index = 3; step();
    cmp("pend_stall_flush", 8'(flush), 8'd0);
    stall = 0; int_req = 0; step();
    cmp("pend_entry_flush", 8'(flush), 8'd1);
    int_req = 1; int_index = 6; step();
    int_req = 0; step(); step(); step();
    cmp("pend_vec_place", 8'(pc_place), 8'd5);
    cmp("pend_vec_index", 8'(index), 8'd3);
    step();
    cmp("pend_no_reentry", 8'(flush), 8'd0);
    step();
    cmp("pend_idle_busy", 8'(busy), 8'd0);
    $display("scenario pending interrupt done");

    // Abort by exception, then by reset
    int_req = 1; int_index = 1; step();
    int_req = 0; step();
    exc_valid = 1; exc_code = 0; step();
    exc_valid = 0;
    cmp("abort_exc_place", 8'(pc_place), 8'd1);
    cmp("abort_exc_busy", 8'(busy), 8'd0);
    step();
    cmp("reentry_busy", 8'(busy), 8'd1);
    step(); step(); step(); step();
    cmp("reentry_vec_index", 8'(index), 8'd1);
    cmp("reentry_ack", 8'(int_ack), 8'd1);
    int_req = 1; int_index = 4; step();
    int_req = 0; step();
    rst_n = 0; step();
    cmp("abort_rst_ack", 8'(int_ack), 8'd0);
    cmp("abort_rst_busy", 8'(busy), 8'd1);
    rst_n = 1; step();
    cmp("abort_rst_boot", 8'(pc_place), 8'd8);
    step(); step();
    cmp("abort_rst_no_ack", 8'(int_ack), 8'd0);
    cmp("abort_rst_seq", 8'(pc_select), 8'd1);
    $display("scenario abort done");

    // Random phase against the model
    for (int i = 0; i < 3000; i++) begin
      rst_n      = ($urandom_range(0, 199) != 0);
      stall      = ($urandom_range(0, 3) == 0);
      inst_is_32 = 1'($urandom_range(0, 1));
      exc_valid  = ($urandom_range(0, 9) == 0);
      exc_code   = 2'($urandom_range(0, 3));
      int_req    = ($urandom_range(0, 11) == 0);
      int_index  = 3'($urandom_range(0, 7));
      call_en    = ($urandom_range(0, 14) == 0);
      ret_en     = ($urandom_range(0, 14) == 0);
      step();
    end
    rst_n = 1; stall = 0; exc_valid = 0; int_req = 0; call_en = 0; ret_en = 0;
    step(); step();
    $display("scenario random done");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/pc_ctrl.md
Name: pc_ctrl

Overview:
- Control-side counterpart of the fetch stage.
- Collects the PC-redirect events: reset sequencing, hardware exceptions, interrupt entry, call/ret redirects, stalls and 32-bit instruction length.
- Drives the encoded pc_place / pc_select / index command bus that fetch samples every clock.
- Owns the interrupt-entry sequence: pend, drain, vector, acknowledge.

Parameters:
- DRAIN_CYCLES, 3: bubble cycles inserted before vectoring to an interrupt (range 1..15).
- CNT_W, 4: width of the drain counter; must hold DRAIN_CYCLES.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  synchronous reset, active-low
- stall  in  1  hazard stall; hold PC
- inst_is_32  in  1  current fetched instruction occupies two words
- exc_valid  in  1  hardware exception pulse
- exc_code  in  2  exception number 0..3
- int_req  in  1  external interrupt request (pulse or level)
- int_index  in  3  interrupt vector index
- call_en  in  1  resolved call; redirect to call target
- ret_en  in  1  resolved return; redirect to popped return address
- pc_place  out  4  redirect code to fetch
- pc_select  out  2  sequential increment code to fetch
- index  out  3  IVT offset to fetch
- flush  out  1  kill younger in-flight instructions
- int_ack  out  1  one-cycle interrupt acknowledge
- busy  out  1  sequence in progress (not RUN)

Behaviour:
- Command encoding (fixed contract with fetch):
  - pc_place: 0 = sequential; 1/2/3/4 = fixed vectors 0/2/4/6; 5 = IVT+index; 6 = ret; 7 = call; 8 = reset address.
  - pc_select (only meaningful when pc_place = 0): 0 = hold, 1 = +1, 2 = +2.
- All outputs are registered.
  - The decision taken at edge N is visible after edge N; fetch consumes it at edge N+1.
- Reset (rst_n low at an edge):
  - state = RST_VEC, pc_place = 0, pc_select = 0, index = 0, flush = 0, int_ack = 0, busy = 1, pending = 0, counter = 0.
- States:
  - RST_VEC: first edge with rst_n high drives pc_place = 8, flush = 1, then goes to RUN.
  - RUN: per-cycle priority (highest first):
    - exc_valid: pc_place = 1 + exc_code, flush = 1. Any pending interrupt is kept.
    - ret_en: pc_place = 6, flush = 1.
    - call_en: pc_place = 7, flush = 1.
    - pending or int_req (and not stall): pc_place = 0, pc_select = 0, flush = 1, counter = DRAIN_CYCLES-1, latch int_index, go to DRAIN.
    - stall: pc_place = 0, pc_select = 0.
    - otherwise: pc_place = 0, pc_select = inst_is_32 ? 2 : 1.
  - DRAIN: pc_place = 0, pc_select = 0, flush = 1.
    - Counter decrements each cycle.
    - When counter is 0, go to VEC.
    - stall does not extend the drain.
  - VEC: pc_place = 5, index = latched index, int_ack = 1, flush = 1, pending cleared, go to RUN.
- busy = 1 in every state except RUN.
- int_req arriving in any state other than RUN (or while stall) sets pending. The first latched index wins; later requests are dropped until int_ack.
- exc_valid during DRAIN:
  - Issue the exception redirect immediately.
  - Abort the drain and return to RUN with pending still set; the interrupt re-enters on the next eligible cycle.
- exc_valid during VEC or RST_VEC is ignored. The producer must hold/retry.
- ret_en or call_en outside RUN is ignored; the pipeline is being flushed.
- index holds its last value except at VEC and reset.
- flush and int_ack are single-cycle unless the state repeats.
- rst_n low mid-sequence (any state) aborts it: pending is lost and RST_VEC is re-entered.

Test Plan:
- Reset release: rst_n low 2 cycles then high; no events -> RST_VEC for one cycle gives pc_place = 8 and flush = 1. The next cycle gives pc_place = 0, pc_select = 1, busy = 0.
- Length and stall: inst_is_32 = 1 -> pc_select = 2. stall = 1 with inst_is_32 = 1 -> pc_select = 0. Release -> 2 again.
- Interrupt entry: int_req pulse with int_index = 5, DRAIN_CYCLES = 3 -> pc_select = 0, flush = 1 for 1 + 3 cycles. Then pc_place = 5, index = 5, int_ack = 1 for one cycle, then sequential.
- Priority: exc_valid with exc_code = 2, ret_en and call_en in the same cycle -> pc_place = 3 only. Next cycle, ret_en alone -> pc_place = 6.
- Pending interrupt: int_req with index 3 during a stall, plus a second int_req with index 6 during DRAIN -> vector uses index 3, single int_ack, no second entry.
- Abort cases: exc_valid (code 0) mid-DRAIN -> pc_place = 1, then the drain restarts and eventually vectors. rst_n low during DRAIN -> no int_ack, and pc_place = 8 after release.
